// File: rtl/adc_conv_sequencer.sv
// rtl/adc_conv_sequencer.sv - SAR ADC start/config sequencer with result FIFO
// Define ADC_SEQ_TIMEOUT_EN to compile in the WAIT_FIN watchdog.
module adc_conv_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int START_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_in,
  input  logic        trigger_in,
  input  logic [15:0] period_in,
  input  logic [15:0] config_1_in,
  input  logic [15:0] config_2_in,
  input  logic        clr_flags_in,
  output logic [15:0] config_1_out,
  output logic [15:0] config_2_out,
  output logic        start_conversion_out,
  input  logic        conversion_finished_in,
  input  logic [15:0] result_in,
  input  logic        rd_en_in,
  output logic [15:0] rd_data_out,
  output logic        rd_valid_out,
  output logic        overflow_out,
  output logic        timeout_out,
  output logic        busy_out
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int SW_W = $clog2(START_WIDTH + 1);
  localparam logic [SW_W-1:0] START_LAST = SW_W'(START_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_FIN,
    S_CAPTURE,
    S_HOLDOFF
  } state_t;

  state_t            state_q, state_d;
  logic [SW_W-1:0]   start_cnt_q, start_cnt_d;
  logic [15:0]       period_cnt_q, period_cnt_d;
  logic [15:0]       cfg1_q, cfg1_d, cfg2_q, cfg2_d;
  logic              start_q;
  logic              sync1_q, sync2_q, hist_q;
  logic              fin_rise;
  logic              fifo_wr, load_start;
  logic              ovf_q;
  logic [AW:0]       wr_ptr_q, rd_ptr_q, fill;
  logic              empty, full, do_rd, do_wr, ovf_set;
  logic [15:0]       mem_q [FIFO_DEPTH];

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES < 4096) ? 12 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              timeout_hit;
  logic              tmo_q;
`else
  logic              unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  assign fin_rise = sync2_q & ~hist_q;

  always_comb begin
    state_d      = state_q;
    start_cnt_d  = start_cnt_q;
    period_cnt_d = (period_cnt_q == 16'hFFFF) ? period_cnt_q : period_cnt_q + 16'd1;
    cfg1_d       = cfg1_q;
    cfg2_d       = cfg2_q;
    fifo_wr      = 1'b0;
    load_start   = 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
    wd_cnt_d     = wd_cnt_q;
    timeout_hit  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (trigger_in || enable_in) load_start = 1'b1;
      end
      S_START: begin
        if (start_cnt_q == START_LAST) begin
          state_d = S_WAIT_FIN;
`ifdef ADC_SEQ_TIMEOUT_EN
          wd_cnt_d = '0;
`endif
        end else begin
          start_cnt_d = start_cnt_q + SW_W'(1);
        end
      end
      S_WAIT_FIN: begin
        if (fin_rise) begin
          fifo_wr = 1'b1;
          state_d = S_CAPTURE;
        end
`ifdef ADC_SEQ_TIMEOUT_EN
        else if (wd_cnt_q == WD_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
`endif
      end
      S_CAPTURE: state_d = enable_in ? S_HOLDOFF : S_IDLE;
      S_HOLDOFF: begin
        if (!enable_in) state_d = S_IDLE;
        else if (period_cnt_q >= period_in) load_start = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Counter holds cycles elapsed since START entry, counting the current one,
    // so HOLDOFF releases exactly period_in cycles after the previous start.
    if (load_start) begin
      state_d      = S_START;
      start_cnt_d  = '0;
      period_cnt_d = 16'd1;
      cfg1_d       = config_1_in;
      cfg2_d       = config_2_in;
    end
  end

  assign fill    = wr_ptr_q - rd_ptr_q;
  assign empty   = (fill == '0);
  assign full    = (fill == (AW+1)'(FIFO_DEPTH));
  assign do_rd   = rd_en_in & ~empty;
  assign do_wr   = fifo_wr & (~full | do_rd);
  assign ovf_set = fifo_wr & full & ~do_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_cnt_q  <= '0;
      period_cnt_q <= '0;
      cfg1_q       <= '0;
      cfg2_q       <= '0;
      start_q      <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hist_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_cnt_q  <= start_cnt_d;
      period_cnt_q <= period_cnt_d;
      cfg1_q       <= cfg1_d;
      cfg2_q       <= cfg2_d;
      start_q      <= (state_d == S_START);
      sync1_q      <= conversion_finished_in;
      sync2_q      <= sync1_q;
      hist_q       <= sync2_q;
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (clr_flags_in) ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= result_in;
  end

`ifdef ADC_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (clr_flags_in) tmo_q <= 1'b0;
      else if (timeout_hit) tmo_q <= 1'b1;
    end
  end
  assign timeout_out = tmo_q;
`else
  assign timeout_out = 1'b0;
`endif

  assign config_1_out         = cfg1_q;
  assign config_2_out         = cfg2_q;
  assign start_conversion_out = start_q;
  assign rd_valid_out         = ~empty;
  assign rd_data_out          = empty ? 16'h0000 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow_out         = ovf_q;
  assign busy_out             = (state_q != S_IDLE);

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// tb/tb_adc_conv_sequencer.sv - self-checking bench for adc_conv_sequencer
module tb_adc_conv_sequencer;
  localparam int DEPTH = 4;
  localparam int SW    = 4;
  localparam int TMO   = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_in = 1'b0, trigger_in = 1'b0, clr_flags_in = 1'b0, rd_en_in = 1'b0;
  logic        conversion_finished_in = 1'b0;
  logic [15:0] period_in = '0, config_1_in = '0, config_2_in = '0, result_in = '0;
  logic [15:0] config_1_out, config_2_out, rd_data_out;
  logic        start_conversion_out, rd_valid_out, overflow_out, timeout_out, busy_out;

  always #5 clk = ~clk;

  adc_conv_sequencer #(.FIFO_DEPTH(DEPTH), .START_WIDTH(SW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .enable_in(enable_in), .trigger_in(trigger_in),
    .period_in(period_in), .config_1_in(config_1_in), .config_2_in(config_2_in),
    .clr_flags_in(clr_flags_in), .config_1_out(config_1_out), .config_2_out(config_2_out),
    .start_conversion_out(start_conversion_out), .conversion_finished_in(conversion_finished_in),
    .result_in(result_in), .rd_en_in(rd_en_in), .rd_data_out(rd_data_out),
    .rd_valid_out(rd_valid_out), .overflow_out(overflow_out), .timeout_out(timeout_out),
    .busy_out(busy_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop();
    rd_en_in = 1'b1;
    @(negedge clk);
    rd_en_in = 1'b0;
  endtask

  task automatic clr();
    clr_flags_in = 1'b1;
    @(negedge clk);
    clr_flags_in = 1'b0;
  endtask

  // One triggered conversion; the ADC answers lat cycles after start falls.
  task automatic run_single(input logic [15:0] c1, input logic [15:0] c2,
                            input logic [15:0] val, input int lat, input bit pop_at_wr);
    int w;
    config_1_in = c1; config_2_in = c2; trigger_in = 1'b1;
    @(negedge clk);
    trigger_in = 1'b0;
    check("start_rise", start_conversion_out, 1);
    check("cfg1_latch", config_1_out, c1);
    check("cfg2_latch", config_2_out, c2);
    config_1_in = ~c1; config_2_in = ~c2;
    w = 0;
    while (start_conversion_out && w < 20) begin w++; @(negedge clk); end
    check("start_width", w, SW);
    repeat (lat) @(negedge clk);
    result_in = val; conversion_finished_in = 1'b1;
    repeat (2) @(negedge clk);
    if (pop_at_wr) rd_en_in = 1'b1;
    @(negedge clk);
    rd_en_in = 1'b0;
    conversion_finished_in = 1'b0;
    w = 0;
    while (busy_out && w < 20) begin w++; @(negedge clk); end
    check("busy_done", busy_out, 0);
    check("cfg1_hold", config_1_out, c1);
  endtask

  typedef struct {
    int          op;       // 0 convert, 1 pop, 2 clear flags
    logic [15:0] val;
    logic        exp_valid;
    logic [15:0] exp_head;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    int period;
    int nconv;
    int rd_pct;
  } phase_t;

  initial begin
    vec_t   vecs[$];
    phase_t phases[5];
    logic [15:0] exp_q[$];
    logic [15:0] exp_fix[4];
    int w;

    vecs.push_back('{0, 16'h0ABC, 1'b1, 16'h0ABC, 1'b0});
    vecs.push_back('{0, 16'h1234, 1'b1, 16'h0ABC, 1'b0});
    vecs.push_back('{0, 16'h5678, 1'b1, 16'h0ABC, 1'b0});
    vecs.push_back('{0, 16'h9ABC, 1'b1, 16'h0ABC, 1'b0});
    vecs.push_back('{0, 16'hDEAD, 1'b1, 16'h0ABC, 1'b1});
    vecs.push_back('{1, 16'h0000, 1'b1, 16'h1234, 1'b1});
    vecs.push_back('{2, 16'h0000, 1'b1, 16'h1234, 1'b0});
    vecs.push_back('{0, 16'h0F0F, 1'b1, 16'h1234, 1'b0});
    vecs.push_back('{1, 16'h0000, 1'b1, 16'h5678, 1'b0});
    vecs.push_back('{0, 16'hC0DE, 1'b1, 16'h5678, 1'b0});
    vecs.push_back('{0, 16'hBAD0, 1'b1, 16'h5678, 1'b1});
    vecs.push_back('{1, 16'h0000, 1'b1, 16'h9ABC, 1'b1});
    vecs.push_back('{1, 16'h0000, 1'b1, 16'h0F0F, 1'b1});
    vecs.push_back('{2, 16'h0000, 1'b1, 16'h0F0F, 1'b0});
    vecs.push_back('{1, 16'h0000, 1'b1, 16'hC0DE, 1'b0});
    vecs.push_back('{1, 16'h0000, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{1, 16'h0000, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{0, 16'h7777, 1'b1, 16'h7777, 1'b0});
    vecs.push_back('{1, 16'h0000, 1'b0, 16'h0000, 1'b0});

    phases = '{'{100, 6, 50}, '{0, 8, 30}, '{37, 6, 10}, '{15, 8, 0}, '{64, 5, 70}};

    repeat (2) @(negedge clk);
    check("rst_cfg1", config_1_out, 0);
    check("rst_cfg2", config_2_out, 0);
    check("rst_start", start_conversion_out, 0);
    check("rst_rdata", rd_data_out, 0);
    check("rst_valid", rd_valid_out, 0);
    check("rst_ovf", overflow_out, 0);
    check("rst_tmo", timeout_out, 0);
    check("rst_busy", busy_out, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        0: run_single((i == 0) ? 16'h0405 : vecs[i].val ^ 16'h5A5A, ~vecs[i].val,
                      vecs[i].val, (i == 0) ? 36 : 2 + (i % 5), 1'b0);
        1: pop();
        default: clr();
      endcase
      check($sformatf("vec%0d_valid", i), rd_valid_out, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_head", i), rd_data_out, vecs[i].exp_head);
      check($sformatf("vec%0d_ovf", i), overflow_out, vecs[i].exp_ovf);
    end

    // Full FIFO with a read landing on the write edge: no overflow, order kept.
    for (int i = 1; i <= 4; i++) run_single(16'h0100, 16'h0200, 16'h1000 + 16'(i), 3, 1'b0);
    run_single(16'h0100, 16'h0200, 16'h1005, 3, 1'b1);
    check("rw_full_ovf", overflow_out, 0);
    exp_fix = '{16'h1002, 16'h1003, 16'h1004, 16'h1005};
    for (int i = 0; i < 4; i++) begin
      check("rw_full_valid", rd_valid_out, 1);
      check("rw_full_order", rd_data_out, exp_fix[i]);
      pop();
    end
    check("rw_full_empty", rd_valid_out, 0);

    // Stale high finished strobe must not capture until a fresh rising edge.
    result_in = 16'hBEEF; conversion_finished_in = 1'b1;
    repeat (3) @(negedge clk);
    trigger_in = 1'b1;
    @(negedge clk);
    trigger_in = 1'b0;
    repeat (30) @(negedge clk);
    check("stale_busy", busy_out, 1);
    check("stale_nocap", rd_valid_out, 0);
    conversion_finished_in = 1'b0;
    repeat (2) @(negedge clk);
    result_in = 16'h2222; conversion_finished_in = 1'b1;
    repeat (3) @(negedge clk);
    conversion_finished_in = 1'b0;
    w = 0;
    while (busy_out && w < 20) begin w++; @(negedge clk); end
    check("fresh_valid", rd_valid_out, 1);
    check("fresh_data", rd_data_out, 16'h2222);
    pop();

    // ADC that never answers.
    trigger_in = 1'b1;
    @(negedge clk);
    trigger_in = 1'b0;
    @(negedge clk);
    repeat (52) @(negedge clk);
    check("tmo_before", timeout_out, 0);
    check("tmo_busy_before", busy_out, 1);
    @(negedge clk);
`ifdef ADC_SEQ_TIMEOUT_EN
    check("tmo_set", timeout_out, 1);
    check("tmo_idle", busy_out, 0);
    check("tmo_fifo", rd_valid_out, 0);
    clr();
    check("tmo_clr", timeout_out, 0);
`else
    check("tmo_tied", timeout_out, 0);
    check("tmo_waits", busy_out, 1);
    result_in = 16'h5555; conversion_finished_in = 1'b1;
    repeat (3) @(negedge clk);
    conversion_finished_in = 1'b0;
    w = 0;
    while (busy_out && w < 20) begin w++; @(negedge clk); end
    check("late_data", rd_data_out, 16'h5555);
    pop();
`endif

    // Asynchronous reset in the middle of a start pulse.
    run_single(16'h0AAA, 16'h0BBB, 16'h3333, 4, 1'b0);
    trigger_in = 1'b1;
    @(negedge clk);
    trigger_in = 1'b0;
    check("pre_rst_start", start_conversion_out, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_start", start_conversion_out, 0);
    check("arst_busy", busy_out, 0);
    check("arst_valid", rd_valid_out, 0);
    check("arst_cfg1", config_1_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_single(16'h0CCC, 16'h0DDD, 16'h4444, 5, 1'b0);
    check("post_rst_data", rd_data_out, 16'h4444);
    pop();

    // Randomized continuous mode against a queue model and spacing rule.
    for (int p = 0; p < 5; p++) begin
      int cyc, guard, starts, last_start, last_lat, adc_cnt, hold, push_at, exp_sp;
      logic [15:0] pend_val, push_val, cfg_prev, exp_cfg;
      logic exp_ovf, prev_start;
      w = 0;
      while (rd_valid_out && w < 10) begin w++; pop(); end
      clr();
      exp_q.delete();
      exp_ovf = 1'b0; prev_start = 1'b0;
      cyc = 0; guard = 0; starts = 0; last_start = 0; last_lat = 0;
      adc_cnt = 0; hold = 0; push_at = -1; pend_val = '0; push_val = '0; exp_cfg = '0;
      cfg_prev = 16'($urandom);
      config_1_in = cfg_prev;
      period_in = 16'(phases[p].period);
      enable_in = 1'b1;
      while (guard < 5000) begin
        @(negedge clk);
        cyc++; guard++;
        if (cyc == push_at) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(push_val);
          else exp_ovf = 1'b1;
          push_at = -1;
        end
        if (hold > 0) begin
          hold--;
          if (hold == 0) conversion_finished_in = 1'b0;
        end
        if (adc_cnt > 0) begin
          adc_cnt--;
          if (adc_cnt == 0) begin
            result_in = pend_val; conversion_finished_in = 1'b1;
            hold = 3; push_at = cyc + 3; push_val = pend_val;
          end
        end
        if (start_conversion_out && !prev_start) begin
          if (starts > 0) begin
            exp_sp = (phases[p].period > last_lat + 5) ? phases[p].period : last_lat + 5;
            check("rand_spacing", cyc - last_start, exp_sp);
          end
          check("rand_cfg_latch", config_1_out, cfg_prev);
          exp_cfg = cfg_prev;
          starts++; last_start = cyc;
          last_lat = $urandom_range(2, 10);
          adc_cnt = last_lat;
          pend_val = 16'($urandom);
          if (starts == phases[p].nconv) enable_in = 1'b0;
        end else if (starts > 0) begin
          check("rand_cfg_hold", config_1_out, exp_cfg);
        end
        prev_start = start_conversion_out;
        check("rand_valid", rd_valid_out, exp_q.size() != 0);
        if (exp_q.size() != 0) check("rand_data", rd_data_out, exp_q[0]);
        check("rand_ovf", overflow_out, exp_ovf);
        rd_en_in = ($urandom_range(0, 99) < phases[p].rd_pct);
        if (rd_en_in && exp_q.size() != 0) void'(exp_q.pop_front());
        cfg_prev = 16'($urandom);
        config_1_in = cfg_prev;
        if (starts == phases[p].nconv && !busy_out && adc_cnt == 0 && hold == 0 && push_at < 0)
          break;
      end
      rd_en_in = 1'b0;
      check($sformatf("phase%0d_done", p), guard < 5000, 1);
      check($sformatf("phase%0d_starts", p), starts, phases[p].nconv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
